updown_sequencer: RTL

//  Controller that sequences the loadable up/down counter in the 1 s timing top level.
//  On start it pulses load for a fixed number of clocks, counts up for UP_TICKS divider

---
 rtl/updown_seq_pkg.sv | 18 +
 rtl/phase_counter.sv | 44 ++++
 rtl/updown_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/updown_seq_pkg.sv
// Shared definitions for the up/down counter sequencer.
// Holds the FSM state encoding and the default phase lengths. The top level
// and the testbench both import this package.
package updown_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

    localparam int DEF_LOAD_CYCLES = 10;
    localparam int DEF_UP_TICKS    = 8;
    localparam int DEF_DOWN_TICKS  = 2;
    localparam int DEF_TICK_W      = 16;

endpackage

// File: rtl/phase_counter.sv
// Tick counter for the UP/DOWN phases of the sequencer.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       synchronous clear, wins over en
//   en        increment by one this clock
//   limit     phase length in ticks; term flags the last tick position
//   cnt       registered count value
//   term      high when cnt == limit-1
module phase_counter #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [TICK_W-1:0] limit,
    output logic [TICK_W-1:0] cnt,
    output logic              term
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == (limit - TICK_W'(1)));

endmodule

// File: rtl/updown_sequencer.sv
// Sequencer driving the load and direction inputs of the loadable up/down
// counter. A start rising edge holds load for LOAD_CYCLES clocks, then the
// counter runs up for UP_TICKS divider ticks and down for DOWN_TICKS ticks,
// after which the sequence either repeats (repeat_en) or finishes with done.
//
// State table
//   state   | meaning
//   IDLE    | waiting for a start rising edge
//   LOAD    | load held high for LOAD_CYCLES clocks, ticks ignored
//   UP      | counting up, phase_cnt counts ticks
//   DOWN    | counting down, phase_cnt counts ticks
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   tick          one-clock pulse from the frequency divider
//   start         level, rising edge launches a sequence from IDLE
//   abort         level, returns to IDLE next clock (highest priority)
//   repeat_en     sampled at the end of DOWN: loop to LOAD or finish
//   load          counter load control
//   up_not_down   counter direction control (1 = up)
//   busy          high in every state except IDLE
//   done          one-clock pulse on normal completion
//   phase_cnt     ticks elapsed in the current UP/DOWN phase
module updown_sequencer
    import updown_seq_pkg::*;
#(
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int UP_TICKS    = DEF_UP_TICKS,
    parameter int DOWN_TICKS  = DEF_DOWN_TICKS,
    parameter int TICK_W      = DEF_TICK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              abort,
    input  logic              repeat_en,
    output logic              load,
    output logic              up_not_down,
    output logic              busy,
    output logic              done,
    output logic [TICK_W-1:0] phase_cnt
);

    localparam int LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic              start_prev_q;
    logic              load_q, load_d;
    logic              up_not_down_q, up_not_down_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              start_rise;
    logic              in_count_phase;
    logic              cnt_en;
    logic              cnt_clr;
    logic              cnt_term;
    logic [TICK_W-1:0] phase_limit;

    assign start_rise     = start && !start_prev_q;
    assign in_count_phase = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign phase_limit    = (state_q == ST_DOWN) ? TICK_W'(DOWN_TICKS) : TICK_W'(UP_TICKS);

    // Ticks only count while the registered state is UP or DOWN, so a tick on
    // the clock that enters UP is dropped. The counter is also cleared on the
    // terminal tick so each phase starts from zero.
    assign cnt_en  = tick && in_count_phase;
    assign cnt_clr = abort || !in_count_phase || (cnt_en && cnt_term);

    phase_counter #(
        .TICK_W (TICK_W)
    ) u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (phase_limit),
        .cnt   (phase_cnt),
        .term  (cnt_term)
    );

    always_comb begin
        state_d    = state_q;
        load_cnt_d = '0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_cnt_q == LOAD_W'(LOAD_CYCLES - 1)) begin
                    state_d = ST_UP;
                end else begin
                    load_cnt_d = load_cnt_q + LOAD_W'(1);
                end
            end
            ST_UP: begin
                if (cnt_en && cnt_term) begin
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (cnt_en && cnt_term) begin
                    if (repeat_en) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_IDLE;
            load_cnt_d = '0;
            done_d     = 1'b0;
        end

        // Outputs are registered copies of what the next state implies.
        load_d        = (state_d == ST_LOAD);
        up_not_down_d = (state_d != ST_DOWN);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            load_cnt_q    <= '0;
            start_prev_q  <= 1'b0;
            load_q        <= 1'b0;
            up_not_down_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            start_prev_q  <= start;
            load_q        <= load_d;
            up_not_down_q <= up_not_down_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign load        = load_q;
    assign up_not_down = up_not_down_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
